mac_acc16_q9: RTL
=================

# mac_acc16_q9

Sequential multiply-accumulate front end for the Q9 datapath. Accepts a stream of signed 16-bit coefficient/sample pairs over a valid/ready handshake and accumulates up to 16 full-precision products into a 36-bit signed sum. It presents the sum with a valid/ready output, directly feeding the 36-bit accumulator input of the combinational round/saturate stage (`mul_add_16q9_acc16`).

## Interface
- `N_TERMS`, default 16: maximum number of products per frame.
- `DW`, default 16: operand width (signed, Q9 for the coefficient `a`).
- `AW`, default 36: accumulator width, `2*DW + $clog2(N_TERMS)`. Must not be overridden independently.
- `clk_i`  in  1: clock; all state updates on the rising edge.
- `rst_ni`  in  1: asynchronous, active-low reset.
- `in_valid_i`  in  1: input beat valid.
- `in_ready_o`  out  1: block accepts a beat this cycle.
- `in_a_i`  in  DW: signed coefficient.
- `in_x_i`  in  DW: signed sample.
- `in_last_i`  in  1: accepted beat is the final term of the frame.
- `out_valid_o`  out  1: `out_acc_o` holds a completed frame sum.
- `out_ready_i`  in  1: consumer takes the sum.
- `out_acc_o`  out  AW: signed frame sum. This is the downstream `b_i`.
- `out_terms_o`  out  $clog2(N_TERMS)+1: number of products in the frame, 1..N_TERMS.

## Operation
- A beat is accepted when `in_valid_i && in_ready_o`.
- Stage 1 registers `prod = in_a_i * in_x_i` as signed 2*DW. Stage 2 sign-extends `prod` to AW bits and adds it to `acc`.
- States:
  - ACCUM: `in_ready_o=1`.
  - FLUSH: `in_ready_o=0`; the last product is draining into `acc`.
  - HOLD: `in_ready_o=0`, `out_valid_o=1`.
- Transitions:
  - ACCUM→FLUSH when an accepted beat has `in_last_i=1`, or when it is the N_TERMS-th accepted beat of the frame. A frame is forced closed at N_TERMS even without `in_last_i`.
  - FLUSH→HOLD unconditionally after 1 cycle.
  - HOLD→ACCUM when `out_ready_i=1`. On this transition `acc` and the term counter clear to 0.
- The term counter increments per accepted beat and is captured into `out_terms_o` on entry to HOLD.
- Overflow is impossible by width choice. The worst case is 16 × (−32768)² = 2^34, which is less than 2^35. No saturation is performed here; that is downstream's job.
- `out_acc_o` and `out_terms_o` are stable throughout HOLD. Values outside HOLD are don't-care, but they must not be X after reset.
- The inputs `in_a_i`, `in_x_i` and `in_last_i` are ignored when no beat is accepted.
- Async reset mid-frame discards the partial sum. There is no recovery of the partial frame.

## Timing
- Reset values:
  - state = ACCUM
  - `in_ready_o` = 1
  - `out_valid_o` = 0
  - `out_acc_o` = 0
  - `out_terms_o` = 0
  - product register = 0
  - product-valid flag = 0
- Latency: final beat accepted in cycle t → FLUSH in t+1 → `out_valid_o`=1 in t+2.
- Throughput: 1 beat/cycle inside a frame. There is a minimum 2-cycle input gap between frames, plus any cycles spent stalled in HOLD.
- Output handshake: `out_valid_o` stays high until `out_ready_i`. After the handshake in cycle h, `in_ready_o`=1 in cycle h+1.
- A product accepted in cycle c is added to `acc` at the end of cycle c+1. Consecutive beats therefore pipeline with no bubble.
- `in_valid_i` deassertion mid-frame is allowed. The frame waits indefinitely and the counter holds.

## Structure
- Shared package `q9_pkg` holds:
  - localparams `Q9_DW=16`, `Q9_FRAC=9`, `Q9_NTERMS=16`, `Q9_AW=36`;
  - typedefs `q9_t` (logic signed [15:0]) and `q9_acc_t` (logic signed [35:0]);
  - the FSM enum `mac_state_e` {ACCUM, FLUSH, HOLD}.

  The round/saturate stage reuses these widths.
- Natural sub-module: `q9_mul_reg`, the registered signed multiplier with a valid flag (stage 1). The FSM, counter and accumulator stay in the top.

## Test plan
1. **Full frame.** Reset. Send 16 beats of a=512 (1.0 in Q9), x=100, without `in_last_i`, and hold `out_ready_i`=1. Expect:
   - `out_acc_o`=819200 and `out_terms_o`=16;
   - `out_valid_o` exactly 2 cycles after the 16th accept.
2. **Early last.** Send 3 beats (a,x) = (2,3), (−4,5), (7,−1), with `in_last_i` on the 3rd. Expect:
   - `out_acc_o`=6−20−7=−21;
   - `out_terms_o`=3.
3. **Worst-case magnitude.** Send 16 beats of a=x=−32768. Expect `out_acc_o`=17179869184 (2^34), positive, with no wrap. Repeat with a=−32768, x=32767. Expect −17179344896.
4. **Backpressure.** Hold `out_ready_i`=0 for 5 cycles after completion of a frame summing to 42. Expect:
   - `out_valid_o` high and `out_acc_o`=42 stable all 5 cycles;
   - `in_ready_o`=0 throughout;
   - on release, `in_ready_o`=1 next cycle, and the next frame (a=1, x=1, last) yields 1, not 43.
5. **Input gaps.** Toggle `in_valid_i` every other cycle across an 8-beat frame of a=x=1 with last on beat 8. Expect `out_acc_o`=8 and `out_terms_o`=8.
6. **Reset mid-frame.** Assert `rst_ni`=0 asynchronously after 5 of 10 beats. Expect all outputs to return to reset values immediately. A subsequent frame of 2 beats (a=x=1, last) yields 2.

Source files
------------

// File: rtl/q9_pkg.sv
// Shared Q9 datapath widths, types and the MAC front-end state encoding.
// The round/saturate stage reuses the same widths.
package q9_pkg;

    localparam int Q9_DW     = 16;
    localparam int Q9_FRAC   = 9;
    localparam int Q9_NTERMS = 16;
    localparam int Q9_AW     = 36;

    typedef logic signed [Q9_DW-1:0] q9_t;
    typedef logic signed [Q9_AW-1:0] q9_acc_t;

    typedef enum logic [1:0] {
        ACCUM,
        FLUSH,
        HOLD
    } mac_state_e;

endpackage

// File: rtl/q9_mul_reg.sv
// Stage 1 of the MAC: registered full-precision signed product with a valid flag.
// The product only loads on an accepted beat; the flag marks it for stage 2.
module q9_mul_reg #(
    parameter int DW = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic signed [DW-1:0]   a,
    input  logic signed [DW-1:0]   x,
    output logic signed [2*DW-1:0] prod,
    output logic                   vld
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod <= '0;
            vld  <= 1'b0;
        end else begin
            vld <= en;
            if (en) begin
                prod <= a * x;
            end
        end
    end

endmodule

// File: rtl/mac_acc16_q9.sv
// Sequential multiply-accumulate front end for the Q9 datapath.
// Accumulates up to N_TERMS signed products per frame and holds the sum.
module mac_acc16_q9
    import q9_pkg::*;
#(
    parameter int N_TERMS = Q9_NTERMS,
    parameter int DW      = Q9_DW,
    parameter int AW      = 2 * DW + $clog2(N_TERMS)
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           in_valid_i,
    output logic                           in_ready_o,
    input  logic signed [DW-1:0]           in_a_i,
    input  logic signed [DW-1:0]           in_x_i,
    input  logic                           in_last_i,
    output logic                           out_valid_o,
    input  logic                           out_ready_i,
    output logic signed [AW-1:0]           out_acc_o,
    output logic [$clog2(N_TERMS):0]       out_terms_o
);

    localparam int CW = $clog2(N_TERMS) + 1;
    localparam int PW = 2 * DW;

    mac_state_e            state;
    logic [CW-1:0]         cnt;
    logic signed [AW-1:0]  acc;
    logic signed [PW-1:0]  prod;
    logic                  prod_vld;
    logic                  accept;
    logic                  close;

    assign accept = in_valid_i && in_ready_o;
    assign close  = in_last_i || (cnt == CW'(N_TERMS - 1));

    q9_mul_reg #(
        .DW (DW)
    ) u_mul (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .en    (accept),
        .a     (in_a_i),
        .x     (in_x_i),
        .prod  (prod),
        .vld   (prod_vld)
    );

    // Ready/valid are registered alongside the state so they never glitch.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= ACCUM;
            in_ready_o  <= 1'b1;
            out_valid_o <= 1'b0;
            cnt         <= '0;
            out_terms_o <= '0;
        end else begin
            unique case (state)
                ACCUM: begin
                    if (accept) begin
                        cnt <= cnt + CW'(1);
                        if (close) begin
                            state      <= FLUSH;
                            in_ready_o <= 1'b0;
                        end
                    end
                end
                FLUSH: begin
                    state       <= HOLD;
                    out_valid_o <= 1'b1;
                    out_terms_o <= cnt;
                end
                HOLD: begin
                    if (out_ready_i) begin
                        state       <= ACCUM;
                        out_valid_o <= 1'b0;
                        in_ready_o  <= 1'b1;
                        cnt         <= '0;
                    end
                end
                default: begin
                    state <= ACCUM;
                end
            endcase
        end
    end

    // No product is in flight during HOLD, so acc is stable there.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc <= '0;
        end else if (state == HOLD && out_ready_i) begin
            acc <= '0;
        end else if (prod_vld) begin
            acc <= acc + {{(AW - PW){prod[PW-1]}}, prod};
        end
    end

    assign out_acc_o = acc;

endmodule
